// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the eight-way round-robin arbiter.
// Imported by rr_pick_8 and rr_arbiter_8.
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_IDX_W    = 3;
  localparam int ARB_MAX_HOLD = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick_8.sv
// Combinational rotate-priority picker: first set request at or after ptr, mod 8.
// Zero latency; no flow control (pure function of req and ptr).
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] ptr,
  output logic [ARB_IDX_W-1:0] idx,
  output logic                 any
);

  logic [ARB_N-1:0]     rot;
  logic [ARB_IDX_W-1:0] enc;

  // Rotating right by ptr puts requester ptr at bit 0, so a fixed LSB-first
  // encode followed by adding ptr back yields the round-robin winner.
  always_comb begin
    rot = ARB_N'({req, req} >> ptr);
    enc = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc = ARB_IDX_W'(i);
      end
    end
  end

  assign any = |req;
  assign idx = enc + ptr;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, registered one-hot grant held until release.
// Grant 1 cycle after req in IDLE; release on done/req drop; ARB_TIMEOUT_EN adds forced release.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDX_W    = ARB_IDX_W,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             release_now;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick_8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign release_now = done | ~req[idx_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       tmo_q, tmo_d;
    logic       hold_expired;

    assign hold_expired = (hold_q == 8'(MAX_HOLD - 1)) & ~release_now;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                idx_d = '0;
                vld_d = 1'b0;
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = N'(1) << pick_idx;
                    idx_d   = pick_idx;
                    vld_d   = 1'b1;
                    ptr_d   = pick_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_GRANT: begin
                // A normal release wins over the hold limit, so timeout only fires alone.
`ifdef ARB_TIMEOUT_EN
                if (release_now || hold_expired) begin
                    tmo_d = hold_expired;
`else
                if (release_now) begin
`endif
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = vld_q;

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among eight requesters. It samples a one-hot-or-multi-hot request vector and issues a registered one-hot grant plus its 3-bit binary index, using the same index encoding as the team's 8-to-3 encoder. The grant is held until the owner releases it. It sits in front of any single-ported datapath resource that the design shares among up to eight clients.

## Interface
- `N`, 8: number of requesters; fixed at 8 for this revision.
- `IDX_W`, 3: width of the grant index; equals log2(N).
- `MAX_HOLD`, 16: maximum number of grant cycles before a forced release. Used only with `ARB_TIMEOUT_EN`. Legal range 2..255.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: synchronous reset, active-low.
- `req`  in  8: request per requester; bit i is requester i; level-sensitive.
- `done`  in  1: release strobe from the current owner; sampled only in `GRANT`.
- `gnt`  out  8: registered one-hot grant; all-zero when idle.
- `gnt_idx`  out  3: binary index of the grant bit; 0 when idle.
- `gnt_valid`  out  1: high exactly when `gnt` is non-zero.
- `timeout`  out  1: one-cycle pulse on a forced release; tied to 0 without `ARB_TIMEOUT_EN`.

## Operation
- State register has two states: `IDLE` and `GRANT`. A 3-bit priority pointer `ptr` holds the first index to search.
- **IDLE:**
  - If `req` is non-zero, select the first set bit searching `ptr`, `ptr+1`, … `ptr+7` (mod 8).
  - Register `gnt` = one-hot of the winner, `gnt_idx` = winner, `gnt_valid` = 1.
  - Set `ptr` = winner+1 mod 8 (7 wraps to 0) and go to `GRANT`.
  - If `req` = 0, stay in `IDLE` with the outputs at zero.
- **GRANT:**
  - Release when `done` = 1 or `req[gnt_idx]` = 0, or on a timeout when that feature is enabled.
  - On release, go to `IDLE`. `gnt`, `gnt_idx` and `gnt_valid` clear on the same edge.
  - Requests from other requesters are ignored while in `GRANT`; there is no preemption.
- Release and re-arbitration take separate cycles, so there is always at least one idle cycle between grants. This gap is intentional, giving the resource a turnaround cycle.
- If `done` and owner request drop arrive together, the result is a single release.
- **Reset** (`rst_n` = 0 at an edge) overrides every other event, including mid-grant: state = `IDLE`, `ptr` = 0, `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0, hold counter = 0.

## Timing
- Grant latency: `req` sampled high at edge k in `IDLE` → `gnt` visible after edge k.
- Release latency: `done` sampled at edge m → `gnt` = 0 after edge m. The earliest next grant appears after edge m+1.
- Grant bandwidth: at most one grant per 2 cycles to the same or a different requester. Each grant lasts at least 1 cycle.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.
- Fairness: with all 8 requests held high and `done` pulsed every grant cycle, grants go 0,1,2,…,7,0, repeating. No requester waits more than 7 grants.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit hold counter clears on entry to `GRANT` and increments each `GRANT` cycle.
  - When the counter reaches `MAX_HOLD`-1 with no other release, the arbiter forces a release on that edge and pulses `timeout` = 1 for one cycle, aligned with `gnt` falling.
  - A normal release on the same edge takes precedence, and `timeout` stays 0.
- **Undefined:** no counter is present, `timeout` is constant 0, and a grant is held indefinitely until `done` or the owner's request drops.

## Structure
- Shared package `arb_pkg` holds:
  - state encoding constants `ST_IDLE` = 0 and `ST_GRANT` = 1;
  - `ARB_N` = 8 and `ARB_IDX_W` = 3;
  - default `ARB_MAX_HOLD` = 16.
- One sub-module, `rr_pick_8`: a combinational rotate-priority encoder.
  - Inputs: `req[7:0]`, `ptr[2:0]`.
  - Outputs: `idx[2:0]`, `any`.
  - Implementation: rotate `req` right by `ptr`, run a fixed LSB-first 8-to-3 priority encode, then add `ptr` mod 8.
- The top level holds the state register, pointer, hold counter and output registers.

## Test plan
- **Single requester:** after reset, `req` = 8'b0000_0100 → next cycle `gnt` = 8'b0000_0100, `gnt_idx` = 2, `ptr` = 3. Pulse `done` → `gnt` = 0 on the next edge.
- **Full rotation:** `req` = 8'hFF held, `done` pulsed in each grant cycle → `gnt_idx` sequence 0,1,…,7,0 with one idle cycle between grants.
- **Wrap-around:** grant 7, then `req` = 8'b0000_0011 → next grant index is 0, not 1, and `ptr` = 1.
- **Implicit release and no preemption:**
  - Owner 5 drops `req[5]` while `req[6]` is high → `gnt` clears, then requester 6 is granted one cycle later.
  - While owner 5 holds, raising `req[0]` has no effect on `gnt`.
- **Reset mid-grant:** `rst_n` = 0 during a grant to requester 4 → all outputs are 0 after that edge. With `req` = 8'hFF after reset, the first grant is index 0.
- **Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD` = 4):** requester 3 holds without `done` → `gnt` is high for exactly 4 cycles, `timeout` = 1 for one cycle as `gnt` falls. The next grant goes to a requester other than 3 if any is requesting.
